// File: rtl/hs_bus_amba_axis_pkg.sv
// Shared helpers for the AXI-Stream FIFO slice: packed-word layout and the
// per-cycle FIFO operation encoding.
package hs_bus_amba_axis_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Optional sideband fields may be zero-width; ports still need at least one bit.
   function automatic int fld_w(input int w);
      return (w > 0) ? w : 1;
   endfunction

   function automatic int word_w(input int data_w, input int strb_w, input int keep_w,
                                 input int id_w, input int dest_w, input int user_w);
      return data_w + strb_w + keep_w + 1 + id_w + dest_w + user_w;
   endfunction

   // Word layout, LSB first: user, dest, id, last, keep, strb, data.
   function automatic int dest_lsb(input int user_w);
      return user_w;
   endfunction

   function automatic int id_lsb(input int user_w, input int dest_w);
      return user_w + dest_w;
   endfunction

   function automatic int last_lsb(input int user_w, input int dest_w, input int id_w);
      return user_w + dest_w + id_w;
   endfunction

   function automatic int keep_lsb(input int user_w, input int dest_w, input int id_w);
      return user_w + dest_w + id_w + 1;
   endfunction

   function automatic int strb_lsb(input int user_w, input int dest_w, input int id_w,
                                   input int keep_w);
      return user_w + dest_w + id_w + 1 + keep_w;
   endfunction

   function automatic int data_lsb(input int user_w, input int dest_w, input int id_w,
                                   input int keep_w, input int strb_w);
      return user_w + dest_w + id_w + 1 + keep_w + strb_w;
   endfunction

endpackage

// File: rtl/hs_bus_amba_axis_if.sv
// AXI-Stream interface bundle with master and slave modports.
interface hs_bus_amba_axis_if
   import hs_bus_amba_axis_pkg::*;
#(
   parameter int TDATA_WIDTH = 8,
   parameter int TID_WIDTH   = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
   parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
);

   logic                            tvalid;
   logic                            tready;
   logic [TDATA_WIDTH-1:0]          tdata;
   logic [fld_w(TSTRB_WIDTH)-1:0]   tstrb;
   logic [fld_w(TKEEP_WIDTH)-1:0]   tkeep;
   logic                            tlast;
   logic [fld_w(TID_WIDTH)-1:0]     tid;
   logic [fld_w(TDEST_WIDTH)-1:0]   tdest;
   logic [fld_w(TUSER_WIDTH)-1:0]   tuser;
   logic                            twakeup;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
      output tready
   );

endinterface

// File: rtl/hs_bus_amba_axis_fifo_ram.sv
// DEPTH x WORD_W register array: one synchronous write port, one asynchronous read port.
module hs_bus_amba_axis_fifo_ram #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hs_bus_amba_axis_w2sif_fifo.sv
// Interface-to-wire AXI-Stream adapter with a first-word-fall-through FIFO.
// Define HS_BUS_AMBA_AXIS_W2SIF_FIFO_PKT_MODE_EN to hold output until whole packets are stored.
module hs_bus_amba_axis_w2sif_fifo
   import hs_bus_amba_axis_pkg::*;
#(
   parameter int TDATA_WIDTH = 8,
   parameter int TID_WIDTH   = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
   parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
   parameter int DEPTH       = 4,
   localparam int LVL_W      = $clog2(DEPTH + 1)
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   hs_bus_amba_axis_if.slave             s_axis_if,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
   output logic [fld_w(TSTRB_WIDTH)-1:0] m_axis_tstrb,
   output logic [fld_w(TKEEP_WIDTH)-1:0] m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic [fld_w(TID_WIDTH)-1:0]   m_axis_tid,
   output logic [fld_w(TDEST_WIDTH)-1:0] m_axis_tdest,
   output logic [fld_w(TUSER_WIDTH)-1:0] m_axis_tuser,
   output logic                          m_axis_twakeup,
   output logic [LVL_W-1:0]              lvl,
   output logic                          full,
   output logic                          empty
);

   localparam int ADDR_W   = $clog2(DEPTH);
   localparam int WORD_W   = word_w(TDATA_WIDTH, TSTRB_WIDTH, TKEEP_WIDTH,
                                    TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
   localparam int DEST_LSB = dest_lsb(TUSER_WIDTH);
   localparam int ID_LSB   = id_lsb(TUSER_WIDTH, TDEST_WIDTH);
   localparam int LAST_LSB = last_lsb(TUSER_WIDTH, TDEST_WIDTH, TID_WIDTH);
   localparam int KEEP_LSB = keep_lsb(TUSER_WIDTH, TDEST_WIDTH, TID_WIDTH);
   localparam int STRB_LSB = strb_lsb(TUSER_WIDTH, TDEST_WIDTH, TID_WIDTH, TKEEP_WIDTH);
   localparam int DATA_LSB = data_lsb(TUSER_WIDTH, TDEST_WIDTH, TID_WIDTH, TKEEP_WIDTH,
                                      TSTRB_WIDTH);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [LVL_W-1:0]  lvl_q;
   logic [LVL_W-1:0]  lvl_nxt;
   logic              full_q;
   logic              empty_q;
   logic              wr_en;
   logic              rd_en;
   fifo_op_e          op;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;

   assign s_axis_if.tready = !full_q;
   assign wr_en            = s_axis_if.tvalid && !full_q;
   assign rd_en            = m_axis_tvalid && m_axis_tready;
   assign op               = fifo_op_e'({wr_en, rd_en});

   assign lvl            = lvl_q;
   assign full           = full_q;
   assign empty          = empty_q;
   assign m_axis_twakeup = s_axis_if.twakeup | !empty_q;

   // Mandatory fields always occupy the word; optional ones only when non-zero width.
   assign wr_word[DATA_LSB +: TDATA_WIDTH] = s_axis_if.tdata;
   assign wr_word[LAST_LSB]                = s_axis_if.tlast;
   assign m_axis_tdata                     = rd_word[DATA_LSB +: TDATA_WIDTH];
   assign m_axis_tlast                     = rd_word[LAST_LSB];

   generate
      if (TSTRB_WIDTH > 0) begin : g_strb
         assign wr_word[STRB_LSB +: TSTRB_WIDTH] = s_axis_if.tstrb;
         assign m_axis_tstrb                     = rd_word[STRB_LSB +: TSTRB_WIDTH];
      end else begin : g_no_strb
         assign m_axis_tstrb = '0;
      end
      if (TKEEP_WIDTH > 0) begin : g_keep
         assign wr_word[KEEP_LSB +: TKEEP_WIDTH] = s_axis_if.tkeep;
         assign m_axis_tkeep                     = rd_word[KEEP_LSB +: TKEEP_WIDTH];
      end else begin : g_no_keep
         assign m_axis_tkeep = '0;
      end
      if (TID_WIDTH > 0) begin : g_id
         assign wr_word[ID_LSB +: TID_WIDTH] = s_axis_if.tid;
         assign m_axis_tid                   = rd_word[ID_LSB +: TID_WIDTH];
      end else begin : g_no_id
         assign m_axis_tid = '0;
      end
      if (TDEST_WIDTH > 0) begin : g_dest
         assign wr_word[DEST_LSB +: TDEST_WIDTH] = s_axis_if.tdest;
         assign m_axis_tdest                     = rd_word[DEST_LSB +: TDEST_WIDTH];
      end else begin : g_no_dest
         assign m_axis_tdest = '0;
      end
      if (TUSER_WIDTH > 0) begin : g_user
         assign wr_word[0 +: TUSER_WIDTH] = s_axis_if.tuser;
         assign m_axis_tuser              = rd_word[0 +: TUSER_WIDTH];
      end else begin : g_no_user
         assign m_axis_tuser = '0;
      end
   endgenerate

   hs_bus_amba_axis_fifo_ram #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (aclk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_word),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   always_comb begin
      lvl_nxt = lvl_q;
      unique case (op)
         OP_WR:   lvl_nxt = lvl_q + LVL_W'(1);
         OP_RD:   lvl_nxt = lvl_q - LVL_W'(1);
         default: lvl_nxt = lvl_q;
      endcase
   end

   // Status flags are registered alongside the pointers so they never glitch.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         lvl_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         lvl_q   <= lvl_nxt;
         full_q  <= (lvl_nxt == LVL_W'(DEPTH));
         empty_q <= (lvl_nxt == '0);
      end
   end

`ifdef HS_BUS_AMBA_AXIS_W2SIF_FIFO_PKT_MODE_EN
   logic [LVL_W-1:0] pkt_cnt;
   logic             releasing;
   logic             wr_last;
   logic             rd_last;

   assign wr_last = wr_en && s_axis_if.tlast;
   assign rd_last = rd_en && m_axis_tlast;

   // releasing keeps valid up for the tail of a packet that was let out early
   // (by the full term) until its tlast beat leaves or the FIFO drains.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_cnt   <= '0;
         releasing <= 1'b0;
      end else begin
         unique case ({wr_last, rd_last})
            2'b10:   pkt_cnt <= pkt_cnt + LVL_W'(1);
            2'b01:   pkt_cnt <= pkt_cnt - LVL_W'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (rd_last || (rd_en && (lvl_nxt == '0))) begin
            releasing <= 1'b0;
         end else if (m_axis_tvalid) begin
            releasing <= 1'b1;
         end
      end
   end

   assign m_axis_tvalid = !empty_q && ((pkt_cnt != '0) || full_q || releasing);
`else
   assign m_axis_tvalid = !empty_q;
`endif

endmodule

// File: tb/tb_hs_bus_amba_axis_w2sif_fifo.sv
// Randomised self-checking bench for hs_bus_amba_axis_w2sif_fifo against a queue model.
module tb_hs_bus_amba_axis_w2sif_fifo;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [7:0] data;
      logic       strb;
      logic       keep;
      logic       last;
      logic       id;
      logic       dest;
      logic       user;
   } beat_t;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic [7:0]       m_axis_tdata;
   logic [0:0]       m_axis_tstrb;
   logic [0:0]       m_axis_tkeep;
   logic             m_axis_tlast;
   logic [0:0]       m_axis_tid;
   logic [0:0]       m_axis_tdest;
   logic [0:0]       m_axis_tuser;
   logic             m_axis_twakeup;
   logic [LVL_W-1:0] lvl;
   logic             full;
   logic             empty;

   int    checks   = 0;
   int    failures = 0;
   beat_t q[$];
   bit    partial  = 1'b0;
   bit    ign;

   always #5 aclk = ~aclk;

   hs_bus_amba_axis_if #(
      .TDATA_WIDTH (8),
      .TID_WIDTH   (1),
      .TDEST_WIDTH (1),
      .TUSER_WIDTH (1)
   ) s_if ();

   hs_bus_amba_axis_w2sif_fifo #(
      .TDATA_WIDTH (8),
      .TID_WIDTH   (1),
      .TDEST_WIDTH (1),
      .TUSER_WIDTH (1),
      .DEPTH       (DEPTH)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_axis_if      (s_if),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tstrb   (m_axis_tstrb),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tid     (m_axis_tid),
      .m_axis_tdest   (m_axis_tdest),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_twakeup (m_axis_twakeup),
      .lvl            (lvl),
      .full           (full),
      .empty          (empty)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit queue_has_last();
      foreach (q[i]) begin
         if (q[i].last) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Packet mode: a beat may leave once its packet is complete, the FIFO is
   // full, or an earlier beat of the same packet has already left.
   function automatic bit model_valid();
      if (q.size() == 0) return 1'b0;
`ifdef HS_BUS_AMBA_AXIS_W2SIF_FIFO_PKT_MODE_EN
      return queue_has_last() || (q.size() == DEPTH) || partial;
`else
      return 1'b1;
`endif
   endfunction

   task automatic applyStimulus(input bit vld, input logic [7:0] data, input bit last,
                                input bit rdy, output bit acc);
      beat_t cur;
      bit    exp_v;
      bit    wr;
      bit    rd;
      cur.data = data;
      cur.last = last;
      cur.strb = 1'($urandom_range(0, 1));
      cur.keep = 1'($urandom_range(0, 1));
      cur.id   = 1'($urandom_range(0, 1));
      cur.dest = 1'($urandom_range(0, 1));
      cur.user = 1'($urandom_range(0, 1));
      s_if.tvalid   = vld;
      s_if.tdata    = cur.data;
      s_if.tlast    = cur.last;
      s_if.tstrb    = cur.strb;
      s_if.tkeep    = cur.keep;
      s_if.tid      = cur.id;
      s_if.tdest    = cur.dest;
      s_if.tuser    = cur.user;
      s_if.twakeup  = 1'($urandom_range(0, 1));
      m_axis_tready = rdy;
      #1;
      exp_v = model_valid();
      checkOutput("tvalid", m_axis_tvalid, exp_v);
      checkOutput("lvl", lvl, q.size());
      checkOutput("full", full, q.size() == DEPTH);
      checkOutput("empty", empty, q.size() == 0);
      checkOutput("s_tready", s_if.tready, q.size() < DEPTH);
      checkOutput("twakeup", m_axis_twakeup, s_if.twakeup | (q.size() != 0));
      if (q.size() != 0) begin
         checkOutput("tdata", m_axis_tdata, q[0].data);
         checkOutput("tlast", m_axis_tlast, q[0].last);
         checkOutput("tstrb", m_axis_tstrb, q[0].strb);
         checkOutput("tkeep", m_axis_tkeep, q[0].keep);
         checkOutput("tid", m_axis_tid, q[0].id);
         checkOutput("tdest", m_axis_tdest, q[0].dest);
         checkOutput("tuser", m_axis_tuser, q[0].user);
      end
      wr  = vld && (q.size() < DEPTH);
      rd  = rdy && exp_v;
      acc = wr;
      @(posedge aclk);
      if (rd) begin
         partial = !q[0].last;
         void'(q.pop_front());
      end
      if (wr) q.push_back(cur);
      if (q.size() == 0) partial = 1'b0;
      @(negedge aclk);
   endtask

   task automatic sendBeat(input logic [7:0] data, input bit last, input bit rdy);
      bit acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
         applyStimulus(1'b1, data, last, rdy, acc);
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("[TB] FAIL send_timeout beat %0h not accepted within 20 cycles", data);
      end
   endtask

   task automatic drain(input int n);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
   endtask

   task automatic doReset();
      aresetn = 1'b0;
      #1;
      checkOutput("rst_tvalid", m_axis_tvalid, 0);
      checkOutput("rst_empty", empty, 1);
      checkOutput("rst_full", full, 0);
      checkOutput("rst_lvl", lvl, 0);
      q.delete();
      partial = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      checkOutput("rst_tready", s_if.tready, 1);
      @(negedge aclk);
   endtask

   initial begin
      aresetn       = 1'b1;
      s_if.tvalid   = 1'b0;
      s_if.tdata    = '0;
      s_if.tlast    = 1'b0;
      s_if.tstrb    = '0;
      s_if.tkeep    = '0;
      s_if.tid      = '0;
      s_if.tdest    = '0;
      s_if.tuser    = '0;
      s_if.twakeup  = 1'b0;
      m_axis_tready = 1'b0;
      @(negedge aclk);
      doReset();

      $display("[TB] single beat latency");
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, ign);
      drain(2);

      $display("[TB] fill to full with sink stalled");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, ign);

      $display("[TB] streaming across pointer wrap");
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, ign);
      drain(6);

      $display("[TB] simultaneous write and read at lvl 2");
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, ign);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b1, ign);
      drain(6);

      $display("[TB] reset mid-burst at lvl 3");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, ign);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, ign);
      doReset();

      $display("[TB] three-beat packet");
      sendBeat(8'h01, 1'b0, 1'b1);
      sendBeat(8'h02, 1'b0, 1'b1);
      sendBeat(8'h03, 1'b1, 1'b1);
      drain(5);

      $display("[TB] packet longer than depth");
      for (int i = 0; i < 6; i++) sendBeat(8'(8'h10 + i), (i == 5), 1'b1);
      drain(6);

      $display("[TB] randomised traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)), ign);
      end
      for (int i = 0; i < 6; i++) sendBeat(8'($urandom), (i == 5), 1'b1);
      drain(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
